kfmmc_read_arbiter: RTL and testbench
=====================================

// Module: kfmmc_read_arbiter
// PURPOSE
//  Shares one KFMMC_DRIVE between two block-read requesters; round-robin arbitration.
//  Per granted request: loads the 32-bit block address, issues the read command (8'h80),
//  streams the 512 data bytes back to the owner and reports completion/error.
//  Sits between the drive and client logic (e.g. a display filler, a loader).
//  Replaces hand-written per-demo sequencers.
// PARAMETERS
//  BLOCK_BYTES     512        bytes expected per block; byte counter width = $clog2(BLOCK_BYTES)+1
//  TIMEOUT_CYCLES  24'hFFFFFF CLOCK_50 cycles without byte/completion in WAIT before abort
// PORTS
//  CLOCK_50               in   1   system clock; drive clocked by ~CLOCK_50 (samples strobes mid-cycle)
//  RESET_N                in   1   asynchronous, active-low reset
//  req0_valid/req1_valid  in   1   read request pending; hold until matching ready
//  req0_lba/req1_lba      in   32  block address of request
//  req0_ready/req1_ready  out  1   1-cycle pulse: request accepted, lba latched
//  byte_valid             out  1   1-cycle pulse: byte_data valid
//  byte_data              out  8   data byte from drive
//  byte_owner             out  1   requester index owning current transfer
//  byte_last              out  1   with byte_valid: byte index == BLOCK_BYTES-1
//  done_valid             out  1   1-cycle pulse: transfer finished
//  done_error             out  1   with done_valid: interface error, timeout or short block
//  drv_data_bus           out  8   to drive data_bus
//  drv_wr_addr[4:1]       out  4   one-hot strobes to write_block_address_1..4
//  drv_wr_command         out  1   strobe to write_command
//  drv_read_data          out  1   strobe to read_data (byte acknowledge / flush)
//  drv_read_data_byte     in   8   drive read_data_byte
//  drv_busy               in   1   drive_busy
//  drv_byte_irq           in   1   read_byte_interrupt
//  drv_done_irq           in   1   read_completion_interrupt
//  drv_if_error           in   1   read_interface_error
// BEHAVIOUR
//  - All state/outputs registered on posedge CLOCK_50. Reset: state=IDLE, all outputs 0,
//    drv_data_bus=8'h00, last_grant=1 (req0 wins first), byte count=0, timeout count=0.
//  - States: IDLE -> FLUSH -> ADDR1 -> ADDR2 -> ADDR3 -> ADDR4 -> CMD -> WAIT <-> BYTE -> ACK; -> DONE -> IDLE.
//  - IDLE: if ~drv_busy and any valid: grant = only valid one; both valid -> ~last_grant.
//    Pulse reqN_ready, latch lba, set owner/last_grant; -> FLUSH. drv_busy=1 blocks grants.
//  - FLUSH: drv_read_data=1 one cycle (clears stale byte). ADDRk: drv_wr_addr[k]=1,
//    drv_data_bus=lba[8k-1:8k-8]. CMD: drv_wr_command=1, drv_data_bus=8'h80. Accept->CMD = 6 cycles.
//  - WAIT: drv_done_irq has priority over drv_byte_irq (same cycle -> DONE, byte dropped).
//    drv_byte_irq -> BYTE: byte_valid=1, byte_data=drv_read_data_byte, count++ -> ACK:
//    drv_read_data=1 one cycle -> WAIT. Bytes beyond BLOCK_BYTES: delivered, byte_last=0, error flagged.
//  - Timeout counter clears on entry to WAIT and on each byte; reaching TIMEOUT_CYCLES -> DONE, error.
//  - DONE: done_valid=1, done_error = drv_if_error | timeout | count != BLOCK_BYTES; -> IDLE.
//  - byte_owner stable from grant through DONE. A withdrawn valid before ready has no effect.
//  - No request queueing: non-granted requester waits; at most one transfer outstanding.
//  - RESET_N low mid-transfer: immediate return to reset values; no done_valid issued.
// TESTING
//  1 req0 lba=32'h12345678 alone -> ready0 pulse; data bus 78,56,34,12 on addr1..4; cmd 80; 6 cycles.
//  2 model returns 512 bytes 00..FF,00..FF -> 512 byte_valid, owner=0, byte_last on 512th; done_error=0.
//  3 req0,req1 both valid from reset, 3 back-to-back -> grants 0,1,0; each full block to correct owner.
//  4 drv_byte_irq and drv_done_irq same cycle after 100 bytes -> DONE, no byte_valid, done_error=1.
//  5 TIMEOUT_CYCLES=1000, model stalls after byte 10 -> done_valid at 1000 cycles, done_error=1.
//  6 RESET_N low during byte 200 then high; drv_busy=1 with req1 valid -> no grant until busy=0.

Source files
------------

// File: rtl/kfmmc_read_arbiter.sv
// Round-robin arbiter sharing one KFMMC drive between two block-read requesters.
// Each grant flushes the drive, loads the LBA, issues the read command and streams the block back.
module kfmmc_read_arbiter #(
    parameter int          BLOCK_BYTES    = 512,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        req0_valid,
    input  logic [31:0] req0_lba,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_lba,
    output logic        req1_ready,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_owner,
    output logic        byte_last,
    output logic        done_valid,
    output logic        done_error,
    output logic [7:0]  drv_data_bus,
    output logic [4:1]  drv_wr_addr,
    output logic        drv_wr_command,
    output logic        drv_read_data,
    input  logic [7:0]  drv_read_data_byte,
    input  logic        drv_busy,
    input  logic        drv_byte_irq,
    input  logic        drv_done_irq,
    input  logic        drv_if_error
);

    localparam int               CNT_W    = $clog2(BLOCK_BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_BYTES);
    localparam logic [7:0]       CMD_READ = 8'h80;

    typedef enum logic [3:0] {
        IDLE, FLUSH, ADDR1, ADDR2, ADDR3, ADDR4, CMD, WAIT, BYTE, ACK, DONE
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [31:0]      lba;
    logic [CNT_W-1:0] byte_cnt;
    logic [23:0]      tmo_cnt;
    logic             if_err_seen;
    logic             grant_sel;

    // Counter saturates so an over-long block can never wrap back to a "correct" count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            lba            <= '0;
            byte_cnt       <= '0;
            tmo_cnt        <= '0;
            if_err_seen    <= 1'b0;
            req0_ready     <= 1'b0;
            req1_ready     <= 1'b0;
            byte_valid     <= 1'b0;
            byte_data      <= 8'h00;
            byte_owner     <= 1'b0;
            byte_last      <= 1'b0;
            done_valid     <= 1'b0;
            done_error     <= 1'b0;
            drv_data_bus   <= 8'h00;
            drv_wr_addr    <= 4'b0000;
            drv_wr_command <= 1'b0;
            drv_read_data  <= 1'b0;
        end else begin
            req0_ready     <= 1'b0;
            req1_ready     <= 1'b0;
            byte_valid     <= 1'b0;
            byte_last      <= 1'b0;
            done_valid     <= 1'b0;
            done_error     <= 1'b0;
            drv_data_bus   <= 8'h00;
            drv_wr_addr    <= 4'b0000;
            drv_wr_command <= 1'b0;
            drv_read_data  <= 1'b0;

            // Outputs are set on the edge that enters the state they belong to.
            case (state)
                IDLE: begin
                    if (!drv_busy && (req0_valid || req1_valid)) begin
                        state         <= FLUSH;
                        drv_read_data <= 1'b1;
                        last_grant    <= grant_sel;
                        byte_owner    <= grant_sel;
                        lba           <= grant_sel ? req1_lba : req0_lba;
                        req0_ready    <= ~grant_sel;
                        req1_ready    <= grant_sel;
                        byte_cnt      <= '0;
                        tmo_cnt       <= '0;
                        if_err_seen   <= 1'b0;
                    end
                end
                FLUSH: begin
                    state        <= ADDR1;
                    drv_wr_addr  <= 4'b0001;
                    drv_data_bus <= lba[7:0];
                end
                ADDR1: begin
                    state        <= ADDR2;
                    drv_wr_addr  <= 4'b0010;
                    drv_data_bus <= lba[15:8];
                end
                ADDR2: begin
                    state        <= ADDR3;
                    drv_wr_addr  <= 4'b0100;
                    drv_data_bus <= lba[23:16];
                end
                ADDR3: begin
                    state        <= ADDR4;
                    drv_wr_addr  <= 4'b1000;
                    drv_data_bus <= lba[31:24];
                end
                ADDR4: begin
                    state          <= CMD;
                    drv_wr_command <= 1'b1;
                    drv_data_bus   <= CMD_READ;
                end
                CMD: begin
                    state   <= WAIT;
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    if (drv_if_error)
                        if_err_seen <= 1'b1;
                    // Completion outranks a coincident byte; that byte is dropped.
                    if (drv_done_irq) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_error <= drv_if_error | if_err_seen | (byte_cnt != FULL_CNT);
                    end else if (drv_byte_irq) begin
                        state      <= BYTE;
                        byte_valid <= 1'b1;
                        byte_data  <= drv_read_data_byte;
                        byte_last  <= (byte_cnt == LAST_IDX);
                        byte_cnt   <= sat_inc(byte_cnt);
                    end else if (tmo_cnt == TIMEOUT_CYCLES - 24'd1) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 24'd1;
                    end
                end
                BYTE: begin
                    state         <= ACK;
                    drv_read_data <= 1'b1;
                end
                ACK: begin
                    state   <= WAIT;
                    tmo_cnt <= '0;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kfmmc_read_arbiter.sv
// Directed bench for kfmmc_read_arbiter: grants, address/command sequence, block streaming,
// completion priority, timeout, mid-transfer reset, busy blocking and over-long blocks.
module tb_kfmmc_read_arbiter;

    localparam int BB = 512;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_lba = '0, req1_lba = '0;
    logic        req0_ready, req1_ready;
    logic        byte_valid, byte_owner, byte_last, done_valid, done_error;
    logic [7:0]  byte_data, drv_data_bus;
    logic [4:1]  drv_wr_addr;
    logic        drv_wr_command, drv_read_data;
    logic [7:0]  drv_read_data_byte = 8'h00;
    logic        drv_busy = 1'b0, drv_byte_irq = 1'b0, drv_done_irq = 1'b0, drv_if_error = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bv_count = 0;
    int dv_count = 0;
    int last_bv_cyc = 0;

    kfmmc_read_arbiter #(.BLOCK_BYTES(BB), .TIMEOUT_CYCLES(24'd1000)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
        .req0_valid(req0_valid), .req0_lba(req0_lba), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_lba(req1_lba), .req1_ready(req1_ready),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_owner(byte_owner),
        .byte_last(byte_last), .done_valid(done_valid), .done_error(done_error),
        .drv_data_bus(drv_data_bus), .drv_wr_addr(drv_wr_addr),
        .drv_wr_command(drv_wr_command), .drv_read_data(drv_read_data),
        .drv_read_data_byte(drv_read_data_byte), .drv_busy(drv_busy),
        .drv_byte_irq(drv_byte_irq), .drv_done_irq(drv_done_irq), .drv_if_error(drv_if_error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (byte_valid) bv_count <= bv_count + 1;
        if (done_valid) dv_count <= dv_count + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge CLOCK_50);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, {req0_ready, req1_ready, byte_valid, byte_data, byte_owner, byte_last,
                  done_valid, done_error, drv_data_bus, drv_wr_addr, drv_wr_command,
                  drv_read_data}, 32'h0);
    endtask

    task automatic wait_grant(input bit exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (req0_ready || req1_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("grant_seen", seen, 1);
        chk("ready0", req0_ready, exp == 1'b0);
        chk("ready1", req1_ready, exp == 1'b1);
        chk("grant_owner", byte_owner, exp);
    endtask

    // Called in the ready cycle: flush strobe now, then ADDR1..4, then CMD five cycles later.
    task automatic addr_phase(input logic [31:0] lba);
        chk("flush_rd", drv_read_data, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLOCK_50);
            chk("addr_strobe", drv_wr_addr, 32'(1 << k));
            chk("addr_bus", drv_data_bus, lba[8*k +: 8]);
        end
        @(negedge CLOCK_50);
        chk("cmd_strobe", drv_wr_command, 1);
        chk("cmd_bus", drv_data_bus, 8'h80);
        chk("cmd_addr_clr", drv_wr_addr, 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit own, input bit last);
        bit got_bv, got_ack;
        got_bv = 1'b0;
        got_ack = 1'b0;
        drv_read_data_byte = d;
        drv_byte_irq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (byte_valid) begin
                got_bv = 1'b1;
                last_bv_cyc = cyc;
                chk("byte_data", byte_data, d);
                chk("byte_owner", byte_owner, own);
                chk("byte_last", byte_last, last);
            end
            if (drv_read_data) begin
                got_ack = 1'b1;
                break;
            end
        end
        drv_byte_irq = 1'b0;
        chk("byte_seen", got_bv, 1);
        chk("byte_ack", got_ack, 1);
    endtask

    task automatic stream(input int n, input bit own);
        for (int i = 0; i < n; i++) send_byte(i[7:0], own, i == BB - 1);
    endtask

    task automatic finish_xfer(input bit own, input bit exp_err);
        bit seen;
        seen = 1'b0;
        drv_done_irq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (done_valid) begin
                seen = 1'b1;
                break;
            end
        end
        drv_done_irq = 1'b0;
        chk("done_seen", seen, 1);
        chk("done_error", done_error, exp_err);
        chk("done_owner", byte_owner, own);
    endtask

    initial begin
        int bv0, dv0;
        bit seen, any_ready;

        // 1: reset state, then req0 alone with address/command sequence
        tick(3);
        chk_reset_outs("reset_outs");
        RESET_N = 1'b1;
        tick(2);
        req0_lba = 32'h12345678;
        req0_valid = 1'b1;
        wait_grant(1'b0);
        req0_valid = 1'b0;
        addr_phase(32'h12345678);

        // 2: full block back to owner 0, clean completion
        bv0 = bv_count;
        stream(BB, 1'b0);
        finish_xfer(1'b0, 1'b0);
        tick(1);
        chk("block_bytes", bv_count - bv0, BB);

        // 3: both valid from reset, three back-to-back grants 0,1,0
        RESET_N = 1'b0;
        tick(2);
        chk_reset_outs("reset2_outs");
        req0_lba = 32'hA1B2C3D4;
        req1_lba = 32'h0F1E2D3C;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        RESET_N = 1'b1;
        wait_grant(1'b0);
        req0_valid = 1'b0;
        addr_phase(32'hA1B2C3D4);
        stream(BB, 1'b0);
        req0_lba = 32'h55AA0102;
        req0_valid = 1'b1;
        finish_xfer(1'b0, 1'b0);
        wait_grant(1'b1);
        req1_valid = 1'b0;
        addr_phase(32'h0F1E2D3C);
        stream(BB, 1'b1);
        req1_valid = 1'b1;
        finish_xfer(1'b1, 1'b0);
        wait_grant(1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        addr_phase(32'h55AA0102);
        stream(BB, 1'b0);
        finish_xfer(1'b0, 1'b0);

        // 4: byte and completion in the same cycle after 100 bytes
        req0_lba = 32'h00000064;
        req0_valid = 1'b1;
        wait_grant(1'b0);
        req0_valid = 1'b0;
        addr_phase(32'h00000064);
        stream(100, 1'b0);
        bv0 = bv_count;
        drv_read_data_byte = 8'hEE;
        drv_byte_irq = 1'b1;
        finish_xfer(1'b0, 1'b1);
        drv_byte_irq = 1'b0;
        tick(2);
        chk("collide_no_byte", bv_count - bv0, 0);

        // 5: stall after 10 bytes, timeout ends the transfer
        req1_lba = 32'hDEADBEEF;
        req1_valid = 1'b1;
        wait_grant(1'b1);
        req1_valid = 1'b0;
        addr_phase(32'hDEADBEEF);
        stream(10, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge CLOCK_50);
            if (done_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("tmo_seen", seen, 1);
        chk("tmo_latency", cyc - last_bv_cyc, 1002);
        chk("tmo_error", done_error, 1);

        // 6: reset during byte 200, then busy blocks grants, withdrawn valid ignored
        req0_lba = 32'h00C0FFEE;
        req0_valid = 1'b1;
        wait_grant(1'b0);
        req0_valid = 1'b0;
        addr_phase(32'h00C0FFEE);
        stream(199, 1'b0);
        drv_read_data_byte = 8'hC7;
        drv_byte_irq = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (byte_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("byte200_seen", seen, 1);
        dv0 = dv_count;
        RESET_N = 1'b0;
        drv_byte_irq = 1'b0;
        #1;
        chk_reset_outs("midreset_outs");
        tick(3);
        RESET_N = 1'b1;
        drv_busy = 1'b1;
        req0_valid = 1'b1;
        tick(2);
        req0_valid = 1'b0;
        req1_lba = 32'h87654321;
        req1_valid = 1'b1;
        any_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (req0_ready || req1_ready) any_ready = 1'b1;
        end
        chk("busy_blocks", any_ready, 0);
        chk("midreset_no_done", dv_count - dv0, 0);
        drv_busy = 1'b0;
        wait_grant(1'b1);
        req1_valid = 1'b0;
        addr_phase(32'h87654321);
        stream(BB, 1'b1);
        drv_if_error = 1'b1;
        finish_xfer(1'b1, 1'b1);
        drv_if_error = 1'b0;

        // 7: one byte beyond the block is delivered without byte_last and flagged
        req0_lba = 32'h00000201;
        req0_valid = 1'b1;
        wait_grant(1'b0);
        req0_valid = 1'b0;
        addr_phase(32'h00000201);
        stream(BB + 1, 1'b0);
        finish_xfer(1'b0, 1'b1);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
